// File: rtl/muldiv_unit_pkg.sv
`default_nettype none
// +--------------------------------------------------------------------+
// | Package : muldiv_unit_pkg                                          |
// | Purpose : Shared constants for the iterative multiply/divide unit: |
// |           op encodings, FSM state encoding, iteration count and a  |
// |           magnitude helper used when operands are latched.         |
// | Rev     : 1.0  initial release                                     |
// +--------------------------------------------------------------------+
package muldiv_unit_pkg;

    // op[1] selects divide, op[0] selects signed arithmetic
    localparam logic [1:0] c_OP_MULTU = 2'b00;
    localparam logic [1:0] c_OP_MULT  = 2'b01;
    localparam logic [1:0] c_OP_DIVU  = 2'b10;
    localparam logic [1:0] c_OP_DIV   = 2'b11;

    localparam logic [1:0] c_ST_IDLE = 2'd0;
    localparam logic [1:0] c_ST_CALC = 2'd1;
    localparam logic [1:0] c_ST_FIX  = 2'd2;

    localparam int unsigned        c_ITERATIONS = 32;
    localparam int unsigned        c_CNT_W      = 5;
    localparam logic [c_CNT_W-1:0] c_LAST_ITER  = c_CNT_W'(c_ITERATIONS - 1);

    // Absolute value of a 32-bit operand when interpreted as signed;
    // 32'h80000000 maps to itself, which is its correct unsigned magnitude.
    function automatic logic [31:0] mag32(input logic [31:0] v, input logic is_signed);
        return (is_signed && v[31]) ? (~v + 32'd1) : v;
    endfunction

endpackage
`default_nettype wire

// File: rtl/muldiv_step.sv
`default_nettype none
// +--------------------------------------------------------------------+
// | Module  : muldiv_step                                              |
// | Purpose : One iteration of the multiply/divide loop on magnitudes. |
// |           Multiply: shift-add, {hi,lo} shifts right, lo[0] gates   |
// |           the add of i_d into hi.                                  |
// |           Divide (MULDIV_DIV_EN only): restoring shift-subtract,   |
// |           hi is the partial remainder, lo collects quotient bits.  |
// | Ports   : i_is_div (divide builds only), i_hi, i_lo, i_d ->        |
// |           o_hi_nxt, o_lo_nxt                                       |
// | Config  : MULDIV_DIV_EN includes the divide path                   |
// | Rev     : 1.0  initial release                                     |
// +--------------------------------------------------------------------+
module muldiv_step
    import muldiv_unit_pkg::*;
(
`ifdef MULDIV_DIV_EN
    input  logic        i_is_div,
`endif
    input  logic [31:0] i_hi,
    input  logic [31:0] i_lo,
    input  logic [31:0] i_d,
    output logic [31:0] o_hi_nxt,
    output logic [31:0] o_lo_nxt
);

    logic [32:0] w_sum;
    logic [31:0] w_mul_hi;
    logic [31:0] w_mul_lo;

    assign w_sum    = {1'b0, i_hi} + (i_lo[0] ? {1'b0, i_d} : 33'd0);
    assign w_mul_hi = w_sum[32:1];
    assign w_mul_lo = {w_sum[0], i_lo[31:1]};

`ifdef MULDIV_DIV_EN
    logic [32:0] w_shift;
    logic [32:0] w_diff;
    logic        w_fits;

    // The partial remainder is always below the divisor, so 33 bits hold
    // both the shifted remainder and the sign of the trial subtraction.
    assign w_shift = {i_hi, i_lo[31]};
    assign w_diff  = w_shift - {1'b0, i_d};
    assign w_fits  = ~w_diff[32];

    assign o_hi_nxt = i_is_div ? (w_fits ? w_diff[31:0] : w_shift[31:0]) : w_mul_hi;
    assign o_lo_nxt = i_is_div ? {i_lo[30:0], w_fits} : w_mul_lo;
`else
    assign o_hi_nxt = w_mul_hi;
    assign o_lo_nxt = w_mul_lo;
`endif

endmodule
`default_nettype wire

// File: rtl/muldiv_unit.sv
`default_nettype none
// +--------------------------------------------------------------------+
// | Module  : muldiv_unit                                              |
// | Purpose : Iterative 32x32 multiply / 32/32 divide for the EX stage.|
// |           Operands latched on the start edge, 32 CALC cycles, one  |
// |           FIX cycle for sign correction; done pulses one cycle     |
// |           after the 33rd edge.                                     |
// | Ports   : clk, rst (async, active high), start, op[1:0], a, b,     |
// |           flush -> busy, done, prod[63:0] = {HI, LO}               |
// | Config  : MULDIV_DIV_EN enables DIV/DIVU; without it divide starts |
// |           are ignored and no divide logic is built                 |
// | Rev     : 1.0  initial release                                     |
// +--------------------------------------------------------------------+
module muldiv_unit
    import muldiv_unit_pkg::*;
(
    input  logic        clk,
    input  logic        rst,
    input  logic        start,
    input  logic [1:0]  op,
    input  logic [31:0] a,
    input  logic [31:0] b,
    input  logic        flush,
    output logic        busy,
    output logic        done,
    output logic [63:0] prod
);

    logic [1:0]         r_state;
    logic [1:0]         w_state_nxt;
    logic [c_CNT_W-1:0] r_cnt;
    logic [31:0]        r_hi;
    logic [31:0]        r_lo;
    logic [31:0]        r_d;
    logic               r_neg_res;
    logic               r_done;
    logic [63:0]        r_prod;
    logic [31:0]        w_hi_nxt;
    logic [31:0]        w_lo_nxt;
    logic [63:0]        w_prod_mag;
    logic [63:0]        w_result;
    logic               w_accept;

`ifdef MULDIV_DIV_EN
    logic               r_is_div;
    logic               r_neg_rem;
    logic               r_div_zero;
    logic [31:0]        r_a;

    assign w_accept = start & ~flush & (r_state == c_ST_IDLE);
`else
    assign w_accept = start & ~flush & (r_state == c_ST_IDLE) & ~op[1];
`endif

    // ---------------- FSM ----------------
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_state <= c_ST_IDLE;
        end else begin
            r_state <= w_state_nxt;
        end
    end

    always_comb begin
        w_state_nxt = r_state;
        case (r_state)
            c_ST_IDLE: if (w_accept) w_state_nxt = c_ST_CALC;
            c_ST_CALC: if (r_cnt == c_LAST_ITER) w_state_nxt = c_ST_FIX;
            c_ST_FIX:  w_state_nxt = c_ST_IDLE;
            default:   w_state_nxt = c_ST_IDLE;
        endcase
        // An abort from the pipeline overrides every transition.
        if (flush) w_state_nxt = c_ST_IDLE;
    end

    // ---------------- iteration step ----------------
    muldiv_step u_step (
`ifdef MULDIV_DIV_EN
        .i_is_div (r_is_div),
`endif
        .i_hi     (r_hi),
        .i_lo     (r_lo),
        .i_d      (r_d),
        .o_hi_nxt (w_hi_nxt),
        .o_lo_nxt (w_lo_nxt)
    );

    // ---------------- sign correction ----------------
    assign w_prod_mag = {r_hi, r_lo};

    always_comb begin
        w_result = r_neg_res ? (~w_prod_mag + 64'd1) : w_prod_mag;
`ifdef MULDIV_DIV_EN
        if (r_is_div) begin
            // Divide by zero leaves the dividend in HI and all-ones in LO
            // regardless of signedness.
            if (r_div_zero) begin
                w_result = {r_a, 32'hFFFF_FFFF};
            end else begin
                w_result = {(r_neg_rem ? (~r_hi + 32'd1) : r_hi),
                            (r_neg_res ? (~r_lo + 32'd1) : r_lo)};
            end
        end
`endif
    end

    // ---------------- datapath and output registers ----------------
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_cnt      <= '0;
            r_hi       <= '0;
            r_lo       <= '0;
            r_d        <= '0;
            r_neg_res  <= 1'b0;
            r_done     <= 1'b0;
            r_prod     <= '0;
`ifdef MULDIV_DIV_EN
            r_is_div   <= 1'b0;
            r_neg_rem  <= 1'b0;
            r_div_zero <= 1'b0;
            r_a        <= '0;
`endif
        end else begin
            r_done <= 1'b0;
            case (r_state)
                c_ST_IDLE: begin
                    if (w_accept) begin
                        // Multiply: lo = multiplier, d = multiplicand.
                        // Divide:   lo = dividend,   d = divisor.
                        r_cnt     <= '0;
                        r_hi      <= '0;
                        r_lo      <= mag32(a, op[0]);
                        r_d       <= mag32(b, op[0]);
                        r_neg_res <= op[0] & (a[31] ^ b[31]);
`ifdef MULDIV_DIV_EN
                        r_is_div   <= op[1];
                        r_neg_rem  <= op[0] & a[31];
                        r_div_zero <= (b == 32'd0);
                        r_a        <= a;
`endif
                    end
                end
                c_ST_CALC: begin
                    r_hi  <= w_hi_nxt;
                    r_lo  <= w_lo_nxt;
                    r_cnt <= r_cnt + 1'b1;
                end
                c_ST_FIX: begin
                    if (!flush) begin
                        r_prod <= w_result;
                        r_done <= 1'b1;
                    end
                end
                default: ;
            endcase
        end
    end

    assign busy = (r_state != c_ST_IDLE);
    assign done = r_done;
    assign prod = r_prod;

endmodule
`default_nettype wire

// File: tb/tb_muldiv_unit.sv
`default_nettype none
// +--------------------------------------------------------------------+
// | Module  : tb_muldiv_unit                                           |
// | Purpose : Self-checking bench for muldiv_unit: directed corner     |
// |           cases plus randomized operations checked against an      |
// |           arithmetic reference model. Honors MULDIV_DIV_EN.        |
// | Rev     : 1.0  initial release                                     |
// +--------------------------------------------------------------------+
module tb_muldiv_unit;

    logic        clk;
    logic        rst;
    logic        start;
    logic [1:0]  op;
    logic [31:0] a;
    logic [31:0] b;
    logic        flush;
    logic        busy;
    logic        done;
    logic [63:0] prod;

    int          n_checks;
    int          n_pass;
    logic [63:0] last_prod;

    muldiv_unit dut (
        .clk   (clk),
        .rst   (rst),
        .start (start),
        .op    (op),
        .a     (a),
        .b     (b),
        .flush (flush),
        .busy  (busy),
        .done  (done),
        .prod  (prod)
    );

    initial begin
        clk = 1'b0;
        forever #5 clk = ~clk;
    end

    initial begin
        #1000000;
        $display("FAIL watchdog: observed no end of test, expected finish");
        $fatal(1, "watchdog expired");
    end

    // Reference result straight from the arithmetic definition.
    function automatic logic [63:0] model(input logic [1:0] m_op, input logic [31:0] x,
                                          input logic [31:0] y);
        longint      sx;
        longint      sy;
        longint      q;
        longint      r;
        logic [63:0] ux;
        logic [63:0] uy;
        logic [63:0] res;
        sx  = longint'($signed(x));
        sy  = longint'($signed(y));
        ux  = {32'd0, x};
        uy  = {32'd0, y};
        res = 64'd0;
        case (m_op)
            2'b00: res = ux * uy;
            2'b01: res = 64'(sx * sy);
            2'b10: begin
                if (y == 32'd0) res = {x, 32'hFFFF_FFFF};
                else            res = {32'(ux % uy), 32'(ux / uy)};
            end
            default: begin
                if (y == 32'd0) begin
                    res = {x, 32'hFFFF_FFFF};
                end else begin
                    q   = sx / sy;
                    r   = sx % sy;
                    res = {r[31:0], q[31:0]};
                end
            end
        endcase
        return res;
    endfunction

    task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        n_checks++;
        assert (obs === exp) n_pass++;
        else $error("FAIL %s: observed %h expected %h", tag, obs, exp);
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    // Issue one operation from an idle sample point and follow it to done.
    // Returns in the done cycle, so a following call starts back-to-back.
    task automatic run_op(input string tag, input logic [1:0] o, input logic [31:0] x,
                          input logic [31:0] y, input logic [63:0] exp);
        int n;
        start = 1'b1;
        op    = o;
        a     = x;
        b     = y;
        tick();
        start = 1'b0;
        a     = $urandom;
        b     = $urandom;
        check({tag, " busy_after_start"}, 64'(busy), 64'd1);
        n = 0;
        while (done !== 1'b1 && n < 40) begin
            tick();
            n++;
        end
        check({tag, " latency"}, 64'(n), 64'd33);
        check({tag, " prod"}, prod, exp);
        check({tag, " busy_in_done"}, 64'(busy), 64'd0);
        last_prod = exp;
    endtask

    // Watch for a stretch of cycles and report how many done pulses appear.
    task automatic count_dones(input int cycles, output int dones);
        dones = 0;
        for (int k = 0; k < cycles; k++) begin
            tick();
            if (done === 1'b1) dones++;
        end
    endtask

    initial begin
        int          n;
        int          dones;
        logic [1:0]  r_op;
        logic [31:0] ra;
        logic [31:0] rb;
        logic [31:0] pool [4];

        n_checks  = 0;
        n_pass    = 0;
        last_prod = 64'd0;
        rst   = 1'b1;
        start = 1'b0;
        flush = 1'b0;
        op    = 2'b00;
        a     = 32'd0;
        b     = 32'd0;
        pool[0] = 32'd0;
        pool[1] = 32'h8000_0000;
        pool[2] = 32'hFFFF_FFFF;
        pool[3] = 32'd1;

        repeat (2) tick();
        check("reset busy", 64'(busy), 64'd0);
        check("reset done", 64'(done), 64'd0);
        check("reset prod", prod, 64'd0);

        // First edge after reset release must accept the start.
        rst = 1'b0;
        run_op("mult_m2x3", 2'b01, 32'hFFFF_FFFE, 32'h0000_0003, 64'hFFFF_FFFF_FFFF_FFFA);
        run_op("multu_max", 2'b00, 32'hFFFF_FFFF, 32'hFFFF_FFFF, 64'hFFFF_FFFE_0000_0001);
        run_op("mult_minsq", 2'b01, 32'h8000_0000, 32'h8000_0000, 64'h4000_0000_0000_0000);

`ifdef MULDIV_DIV_EN
        run_op("div_m7d2", 2'b11, 32'hFFFF_FFF9, 32'd2, {32'hFFFF_FFFF, 32'hFFFF_FFFD});
        run_op("divu_zero", 2'b10, 32'd5, 32'd0, {32'h0000_0005, 32'hFFFF_FFFF});
        run_op("div_ovf", 2'b11, 32'h8000_0000, 32'hFFFF_FFFF, {32'h0, 32'h8000_0000});
        run_op("div_zero_neg", 2'b11, 32'hFFFF_FFF9, 32'd0, {32'hFFFF_FFF9, 32'hFFFF_FFFF});
        run_op("divu_big", 2'b10, 32'hFFFF_FFFF, 32'd7, {32'h0000_0003, 32'h2492_4924});
`else
        // Divide requests are ignored entirely when the divider is absent.
        tick();
        start = 1'b1;
        op    = 2'b11;
        a     = 32'd100;
        b     = 32'd7;
        tick();
        start = 1'b0;
        check("nodiv busy", 64'(busy), 64'd0);
        count_dones(40, dones);
        check("nodiv dones", 64'(dones), 64'd0);
        check("nodiv prod", prod, last_prod);
`endif

        // Randomized operations against the reference model.
        for (int i = 0; i < 16; i++) begin
`ifdef MULDIV_DIV_EN
            r_op = 2'($urandom_range(0, 3));
`else
            r_op = {1'b0, 1'($urandom_range(0, 1))};
`endif
            ra = ($urandom_range(0, 3) == 0) ? pool[$urandom_range(0, 3)] : $urandom;
            rb = ($urandom_range(0, 3) == 0) ? pool[$urandom_range(0, 3)] : $urandom;
            run_op("random", r_op, ra, rb, model(r_op, ra, rb));
        end

        // A second start while busy must not disturb the operation in flight.
        tick();
        start = 1'b1;
        op    = 2'b00;
        a     = 32'd6;
        b     = 32'd7;
        tick();
        start = 1'b0;
        repeat (4) tick();
        start = 1'b1;
        op    = 2'b01;
        a     = 32'hFFFF_FFFF;
        b     = 32'd5;
        tick();
        start = 1'b0;
        n = 5;
        while (done !== 1'b1 && n < 40) begin
            tick();
            n++;
        end
        check("busy_start latency", 64'(n), 64'd33);
        check("busy_start prod", prod, 64'd42);
        last_prod = 64'd42;

        // Flush at cycle 10 of a MULT: no done, prod keeps its prior value.
        tick();
        start = 1'b1;
        op    = 2'b01;
        a     = 32'd1234;
        b     = 32'hFFFF_FF00;
        tick();
        start = 1'b0;
        repeat (9) tick();
        flush = 1'b1;
        tick();
        flush = 1'b0;
        check("flush busy", 64'(busy), 64'd0);
        count_dones(40, dones);
        check("flush dones", 64'(dones), 64'd0);
        check("flush prod", prod, last_prod);

        // Flush wins over a simultaneous start.
        start = 1'b1;
        flush = 1'b1;
        op    = 2'b00;
        tick();
        start = 1'b0;
        flush = 1'b0;
        check("flush_vs_start busy", 64'(busy), 64'd0);

        // Back-to-back: second start lands in the first op's done cycle.
        run_op("b2b_first", 2'b00, 32'd1000, 32'd1000, 64'd1000000);
        run_op("b2b_second", 2'b01, 32'hFFFF_FFFF, 32'hFFFF_FFFF, 64'd1);

        // Asynchronous reset in the middle of CALC.
        tick();
        start = 1'b1;
        op    = 2'b00;
        a     = 32'd77;
        b     = 32'd88;
        tick();
        start = 1'b0;
        repeat (10) tick();
        #2;
        rst = 1'b1;
        #1;
        check("rst_mid busy", 64'(busy), 64'd0);
        check("rst_mid done", 64'(done), 64'd0);
        check("rst_mid prod", prod, 64'd0);
        tick();
        rst = 1'b0;
        run_op("after_rst multu", 2'b00, 32'd3, 32'd4, 64'hC);

        $display("%0d/%0d checks passed", n_pass, n_checks);
        $finish;
    end

endmodule
`default_nettype wire
